// File: rtl/shared_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shared_reg_rr_arbiter
//  Description : Round-robin arbiter sharing one W-bit register between N
//                requesters. At most one requester wins per cycle. The
//                winner's data is loaded into q and a one-cycle one-hot grant
//                pulse is returned one cycle later.
//                Optional macro SHARED_REG_LOCK_EN adds a lock[N] input that
//                lets the current winner keep exclusive ownership.
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_reg_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         wdata,
`ifdef SHARED_REG_LOCK_EN
    input  logic [N-1:0]           lock,
`endif
    output logic [N-1:0]           grant,
    output logic [W-1:0]           q,
    output logic                   q_valid,
    output logic [$clog2(N)-1:0]   owner
);

    localparam int PW = $clog2(N);

    // Round-robin search from index p with wrap at N.
    // Result: {found, index}.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(p) + off;
            if (idx >= N) idx = idx - N;
            if (!res[PW] && r[PW'(idx)]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    logic [PW-1:0] ptr;
    logic          win;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] next_ptr;
    // hold=1: a lock is active, so only the lock owner may win and ptr freezes
    logic          hold;

`ifdef SHARED_REG_LOCK_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] lock_idx;
    logic [PW-1:0] lock_idx_next;

    // Winner selection; a held lock bypasses the round-robin search
    always_comb begin
        logic [PW:0] pick;
        win     = 1'b0;
        win_idx = '0;
        hold    = (state == ST_LOCKED) && lock[lock_idx];
        pick    = rr_pick(req, ptr);
        if (hold) begin
            if (req[lock_idx]) begin
                win     = 1'b1;
                win_idx = lock_idx;
            end
        end else begin
            win     = pick[PW];
            win_idx = pick[PW-1:0];
        end
    end

    // Lock FSM next state: enter on a locked win, leave when the owner drops lock
    always_comb begin
        state_next    = state;
        lock_idx_next = lock_idx;
        if (!hold) begin
            state_next = ST_IDLE;
            if (win && lock[win_idx]) begin
                state_next    = ST_LOCKED;
                lock_idx_next = win_idx;
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state    <= ST_IDLE;
            lock_idx <= '0;
        end else begin
            state    <= state_next;
            lock_idx <= lock_idx_next;
        end
    end
`else
    // Pure round-robin winner selection
    always_comb begin
        logic [PW:0] pick;
        pick    = rr_pick(req, ptr);
        hold    = 1'b0;
        win     = pick[PW];
        win_idx = pick[PW-1:0];
    end
`endif

    // Pointer moves just past the winner; explicit wrap since N may not be 2^k
    assign next_ptr = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;

    // Shared register, grant pulse, owner and round-robin pointer
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            grant   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
            ptr     <= '0;
        end else begin
            grant <= win ? (N'(1) << win_idx) : '0;
            if (win) begin
                q       <= wdata[win_idx*W +: W];
                owner   <= win_idx;
                q_valid <= 1'b1;
                if (!hold) ptr <= next_ptr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_reg_rr_arbiter
//  Description : Self-checking bench for shared_reg_rr_arbiter: directed
//                scenarios plus randomized traffic against a behavioural model.
//                Lock scenarios are built when SHARED_REG_LOCK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_reg_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             sync_reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   wdata;
    logic [N-1:0]     lock;
    logic [N-1:0]     grant;
    logic [W-1:0]     q;
    logic             q_valid;
    logic [$clog2(N)-1:0] owner;

    int vectors  = 0;
    int mismatch = 0;

    // Reference model state
    int           m_ptr;
    logic [N-1:0] m_grant;
    logic [W-1:0] m_q;
    logic         m_qv;
    int           m_owner;
    bit           m_locked;
    int           m_lk;

    shared_reg_rr_arbiter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .req        (req),
        .wdata      (wdata),
`ifdef SHARED_REG_LOCK_EN
        .lock       (lock),
`endif
        .grant      (grant),
        .q          (q),
        .q_valid    (q_valid),
        .owner      (owner)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            mismatch++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: apply the arbitration rules to the inputs present at the coming edge
    task automatic model_update();
        int  winner;
        bit  held;
        winner = -1;
        held   = 1'b0;
        if (sync_reset) begin
            m_ptr = 0; m_grant = '0; m_q = '0; m_qv = 1'b0; m_owner = 0;
            m_locked = 1'b0; m_lk = 0;
            return;
        end
`ifdef SHARED_REG_LOCK_EN
        if (m_locked && lock[m_lk]) begin
            held = 1'b1;
            if (req[m_lk]) winner = m_lk;
        end
`endif
        if (!held) begin
            m_locked = 1'b0;
            for (int off = 0; off < N; off++) begin
                int k;
                k = (m_ptr + off) % N;
                if (winner < 0 && req[k]) winner = k;
            end
        end
        m_grant = '0;
        if (winner >= 0) begin
            m_grant[winner] = 1'b1;
            m_q     = wdata[winner*W +: W];
            m_owner = winner;
            m_qv    = 1'b1;
            if (!held) begin
                m_ptr = (winner + 1) % N;
`ifdef SHARED_REG_LOCK_EN
                if (lock[winner]) begin
                    m_locked = 1'b1;
                    m_lk     = winner;
                end
`endif
            end
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge
    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N*W-1:0] d,
                        input logic [N-1:0] lk);
        sync_reset = rst;
        req        = r;
        wdata      = d;
        lock       = lk;
        model_update();
        @(posedge clk);
        #1;
        check_value("grant",   32'(grant),   32'(m_grant));
        check_value("q",       32'(q),       32'(m_q));
        check_value("q_valid", 32'(q_valid), 32'(m_qv));
        check_value("owner",   32'(owner),   32'(m_owner));
    endtask

    localparam logic [N*W-1:0] DATA = {8'h44, 8'h33, 8'h22, 8'h11};

    initial begin
        logic [N-1:0] exp_seq [8];
        sync_reset = 1'b1; req = '0; wdata = '0; lock = '0;
        m_ptr = 0; m_grant = '0; m_q = '0; m_qv = 1'b0; m_owner = 0; m_locked = 1'b0; m_lk = 0;
        @(posedge clk); #1;

        // Reset with all requesting
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'b1111, DATA, '0);
            check_value("rst_grant", 32'(grant), 32'h0);
            check_value("rst_q", 32'(q), 32'h0);
            check_value("rst_qv", 32'(q_valid), 32'h0);
            check_value("rst_owner", 32'(owner), 32'h0);
        end

        // Single request
        step(1'b0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, '0);
        check_value("single_grant", 32'(grant), 32'h4);
        check_value("single_q", 32'(q), 32'hA5);
        check_value("single_owner", 32'(owner), 32'h2);
        check_value("single_qv", 32'(q_valid), 32'h1);
        step(1'b0, 4'b0000, DATA, '0);
        check_value("single_idle", 32'(grant), 32'h0);
        check_value("single_hold", 32'(q), 32'hA5);

        // All requesting from a fresh pointer
        step(1'b1, 4'b0000, DATA, '0);
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1111, DATA, '0);
            check_value("all_grant", 32'(grant), 32'(exp_seq[i]));
        end

        // Wrap after grant to 3
        step(1'b0, 4'b1001, DATA, '0);
        check_value("wrap_g0", 32'(grant), 32'h1);
        step(1'b0, 4'b1001, DATA, '0);
        check_value("wrap_g3", 32'(grant), 32'h8);
        check_value("wrap_q", 32'(q), 32'h44);

        // Reset mid-burst
        step(1'b0, 4'b1111, DATA, '0);
        check_value("burst_g1", 32'(grant), 32'h1);
        step(1'b0, 4'b1111, DATA, '0);
        check_value("burst_g2", 32'(grant), 32'h2);
        step(1'b1, 4'b1111, DATA, '0);
        check_value("burst_rst", 32'(grant), 32'h0);
        step(1'b0, 4'b1111, DATA, '0);
        check_value("burst_restart", 32'(grant), 32'h1);

`ifdef SHARED_REG_LOCK_EN
        // Lock held by requester 1, then released
        step(1'b1, 4'b0000, DATA, '0);
        step(1'b0, 4'b0010, DATA, 4'b0010);
        check_value("lock_g0", 32'(grant), 32'h2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0011, DATA, 4'b0010);
            check_value("lock_hold", 32'(grant), 32'h2);
        end
        step(1'b0, 4'b0011, DATA, 4'b0000);
        check_value("lock_release", 32'(grant), 32'h1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0]   r;
            logic [N*W-1:0] d;
            logic [N-1:0]   lk;
            r  = N'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            d  = {$urandom, $urandom};
            lk = N'($urandom & $urandom);
            step(($urandom_range(0, 63) == 0), r, d, lk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, mismatch);
        $finish;
    end

endmodule
`default_nettype wire
